// File: rtl/word_splitter.sv
// Splits each accepted 16-bit word into two bytes on a valid/ready byte stream,
// lead byte first; a holding register plus a three-state FSM give one byte per cycle.
module word_splitter #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_word,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        out_first,
  output logic        out_last,
  input  logic        out_ready,
  output logic [7:0]  word_count,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] hold;
  logic        in_xfer;
  logic        out_xfer;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, and in_ready only follows out_ready while the trailing byte is up.
  assign in_ready  = !rst && ((state == IDLE) || ((state == SECOND) && out_ready));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign fsm_state = state;

  function automatic logic [7:0] lead_byte(input logic [15:0] w);
    return LOW_FIRST ? w[7:0] : w[15:8];
  endfunction

  function automatic logic [7:0] trail_byte(input logic [15:0] w);
    return LOW_FIRST ? w[15:8] : w[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= 16'd0;
      word_count <= 8'd0;
      out_valid  <= 1'b0;
      out_byte   <= 8'd0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            hold      <= in_word;
            state     <= FIRST;
            out_valid <= 1'b1;
            out_first <= 1'b1;
            out_last  <= 1'b0;
            out_byte  <= lead_byte(in_word);
          end
        end
        FIRST: begin
          if (out_xfer) begin
            state     <= SECOND;
            out_first <= 1'b0;
            out_last  <= 1'b1;
            out_byte  <= trail_byte(hold);
          end
        end
        SECOND: begin
          if (out_xfer) begin
            word_count <= word_count + 8'd1;
            // A word arriving with the trailing byte's transfer goes straight to FIRST.
            if (in_xfer) begin
              hold      <= in_word;
              state     <= FIRST;
              out_valid <= 1'b1;
              out_first <= 1'b1;
              out_last  <= 1'b0;
              out_byte  <= lead_byte(in_word);
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
              out_byte  <= 8'd0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_first <= 1'b0;
          out_last  <= 1'b0;
          out_byte  <= 8'd0;
        end
      endcase
    end
  end

endmodule
